// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register for the 5-stage RV32I pipeline.
// Chooses the next PC from the EX-stage redirect select and fetches from a
// combinational instruction memory. A taken redirect squashes the wrong-path
// instruction in IF/ID and is exported so the hazard unit can flush ID/EX.
module fetch_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stallF,
   input  logic            stallD,
   input  logic            flushD,
   input  logic [1:0]      PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic [XLEN-1:0] ALUResultE,
   input  logic [31:0]     instrF,
   output logic [XLEN-1:0] PCF,
   output logic [31:0]     instrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            validD,
   output logic            redirectE,
   output logic            misalignE
);

   // Encoding of the EX-stage next-PC select.
   typedef enum logic [1:0] {
      PC_SEQ  = 2'b00,
      PC_REL  = 2'b01,
      PC_JALR = 2'b10,
      PC_RSVD = 2'b11
   } pcsrc_e;

   pcsrc_e          pcsrc;
   logic [XLEN-1:0] pcplus4f;
   logic [XLEN-1:0] nextpc;
   logic            squashd;

   assign pcsrc    = pcsrc_e'(PCSrcE);
   // Wraps modulo 2^XLEN, so the top word of the address space rolls to 0.
   assign pcplus4f = PCF + XLEN'(4);

   // Next-PC select; only the two real redirect encodings flag a redirect.
   always_comb begin
      // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
      nextpc    = pcplus4f;
      redirectE = 1'b0;
      case (pcsrc)
         PC_REL: begin
            nextpc    = PCTargetE;
            redirectE = 1'b1;
         end
         PC_JALR: begin
            // JALR target has bit 0 forced to zero before it is used.
            nextpc    = ALUResultE & ~XLEN'(1);
            redirectE = 1'b1;
         end
         default: begin
            // Sequential and reserved both fall through to PC+4 with no redirect.
            nextpc    = pcplus4f;
            redirectE = 1'b0;
         end
      endcase
   end

   // Misalignment is reported only; the target is still taken as-is.
   assign misalignE = redirectE && (nextpc[1:0] != 2'b00);

   // Any squash source overrides an IF/ID stall.
   assign squashd = redirectE | flushD;

   // PC register: reset, then redirect beats stall, then sequential advance.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         PCF <= RESET_PC;
      end else if (redirectE) begin
         PCF <= nextpc;
      end else if (!stallF) begin
         PCF <= pcplus4f;
      end
   end

   // IF/ID register: reset, then squash to a bubble, then hold on stall, else capture.
   always_ff @(posedge clk) begin
      if (!rst || squashd) begin
         instrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         validD   <= 1'b0;
      end else if (!stallD) begin
         instrD   <= instrF;
         PCD      <= PCF;
         PCPlus4D <= pcplus4f;
         validD   <= 1'b1;
      end
   end

endmodule
